// File: rtl/pwm_defs.sv
// Shared constants, FSM encoding and period-top helper for the PWM sequencer.
package pwm_defs;

  localparam int unsigned WIDTH   = 10;
  localparam int unsigned PRE_W   = 8;
  localparam int unsigned TOP_MAX = 1022;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } pwm_state_t;

  // Effective terminal count: 0 is promoted to 1, large values capped at TOP_MAX.
  function automatic logic [WIDTH-1:0] eff_top(input logic [WIDTH-1:0] p);
    logic [WIDTH-1:0] r;
    r = p;
    if (p == '0) r = WIDTH'(1);
    else if (p > WIDTH'(TOP_MAX)) r = WIDTH'(TOP_MAX);
    return r;
  endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Clock-enable divider: one tick every prescale+1 clocks while enabled.
module pwm_prescaler
  import pwm_defs::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [PRE_W-1:0] prescale,
  output logic             tick
);

  logic [PRE_W-1:0] cnt_q;

  // >= keeps the divider from running away if prescale is lowered live
  assign tick = en && (cnt_q >= prescale);

  always_ff @(posedge clk) begin
    if (reset || !en || tick) cnt_q <= '0;
    else                      cnt_q <= cnt_q + PRE_W'(1);
  end

endmodule

// File: rtl/pwm_ciclo_ctrl.sv
// PWM carrier/reference sequencer with period-boundary duty update and
// IDLE/RUN/DRAIN control so a stop always finishes the current period.
module pwm_ciclo_ctrl
  import pwm_defs::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] period_top,
  input  logic [PRE_W-1:0] prescale,
  input  logic [WIDTH-1:0] duty_in,
  input  logic             duty_valid,
  output logic             duty_ready,
  output logic [WIDTH-1:0] Frec_Conm,
  output logic [WIDTH-1:0] Corri_Ref,
  output logic             period_start,
  output logic             running,
  output logic             duty_clamped
);

  pwm_state_t       state_q, state_d;
  logic [WIDTH-1:0] top_q, top_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0] cnt_d, ref_d;
  logic [WIDTH-1:0] top_new, lim_new;
  logic             ready_d, ps_d, run_d, clamp_d;
  logic             tick, wrap, xfer;

  assign top_new = eff_top(period_top);
  assign lim_new = top_new + WIDTH'(1);
  assign wrap    = tick && (Frec_Conm == top_q);

  pwm_prescaler u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .en       (state_q != ST_IDLE),
    .prescale (prescale),
    .tick     (tick)
  );

  // Next-state, counter and duty-transfer logic
  always_comb begin
    state_d  = state_q;
    top_d    = top_q;
    shadow_d = shadow_q;
    cnt_d    = Frec_Conm;
    ref_d    = Corri_Ref;
    ready_d  = duty_ready;
    ps_d     = 1'b0;
    clamp_d  = 1'b0;
    xfer     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        ref_d = '0;
        if (enable) begin
          state_d = ST_RUN;
          ps_d    = 1'b1;
          top_d   = top_new;
          xfer    = 1'b1;
        end
      end
      ST_RUN, ST_DRAIN: begin
        if (state_q == ST_RUN && !enable)       state_d = ST_DRAIN;
        else if (state_q == ST_DRAIN && enable) state_d = ST_RUN;
        if (tick) begin
          if (!wrap) begin
            cnt_d = Frec_Conm + WIDTH'(1);
          end else if (state_q == ST_DRAIN && !enable) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            ref_d   = '0;
          end else begin
            cnt_d = '0;
            ps_d  = 1'b1;
            top_d = top_new;
            xfer  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Pending shadow moves to the reference only at a period start
    if (xfer && !duty_ready) begin
      ref_d   = (shadow_q > lim_new) ? lim_new : shadow_q;
      clamp_d = (shadow_q > lim_new);
      ready_d = 1'b1;
    end

    // Accept is exclusive with transfer: it requires the slot to be empty
    if (duty_valid && duty_ready) begin
      shadow_d = duty_in;
      ready_d  = 1'b0;
    end

    run_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      top_q        <= '0;
      shadow_q     <= '0;
      Frec_Conm    <= '0;
      Corri_Ref    <= '0;
      duty_ready   <= 1'b1;
      period_start <= 1'b0;
      running      <= 1'b0;
      duty_clamped <= 1'b0;
    end else begin
      state_q      <= state_d;
      top_q        <= top_d;
      shadow_q     <= shadow_d;
      Frec_Conm    <= cnt_d;
      Corri_Ref    <= ref_d;
      duty_ready   <= ready_d;
      period_start <= ps_d;
      running      <= run_d;
      duty_clamped <= clamp_d;
    end
  end

endmodule

// File: tb/tb_pwm_ciclo_ctrl.sv
// Bench for pwm_ciclo_ctrl: directed scenarios plus random traffic against a
// period/phase-based reference model.
module tb_pwm_ciclo_ctrl;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [9:0] period_top;
  logic [7:0] prescale;
  logic [9:0] duty_in;
  logic       duty_valid;
  logic       duty_ready;
  logic [9:0] Frec_Conm;
  logic [9:0] Corri_Ref;
  logic       period_start;
  logic       running;
  logic       duty_clamped;

  int n_checks = 0;
  int n_fail   = 0;

  pwm_ciclo_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .period_top   (period_top),
    .prescale     (prescale),
    .duty_in      (duty_in),
    .duty_valid   (duty_valid),
    .duty_ready   (duty_ready),
    .Frec_Conm    (Frec_Conm),
    .Corri_Ref    (Corri_Ref),
    .period_start (period_start),
    .running      (running),
    .duty_clamped (duty_clamped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: position in the period is a clock phase; carrier = phase/(pre+1)
  bit m_valid = 1'b0;
  bit m_on, m_drain, m_pend, m_ps, m_clamp;
  int m_phase, m_top, m_ref, m_shadow;

  function automatic int eff(input int p);
    if (p == 0) return 1;
    if (p > 1022) return 1022;
    return p;
  endfunction

  task automatic model_start();
    m_top = eff(int'(period_top));
    m_ps  = 1'b1;
    if (m_pend) begin
      m_clamp = (m_shadow > m_top + 1);
      m_ref   = m_clamp ? m_top + 1 : m_shadow;
      m_pend  = 1'b0;
    end
  endtask

  always @(posedge clk) begin
    bit acc, last;
    if (reset) begin
      m_on = 0; m_drain = 0; m_pend = 0; m_ps = 0; m_clamp = 0;
      m_phase = 0; m_top = 0; m_ref = 0; m_shadow = 0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      acc  = duty_valid && !m_pend;
      last = m_on && (m_phase == (m_top + 1) * (int'(prescale) + 1) - 1);
      m_ps = 1'b0;
      m_clamp = 1'b0;
      if (!m_on) begin
        m_ref = 0;
        if (enable) begin
          m_on = 1'b1; m_drain = 1'b0; m_phase = 0;
          model_start();
        end
      end else if (last) begin
        if (m_drain && !enable) begin
          m_on = 1'b0; m_phase = 0; m_ref = 0;
        end else begin
          m_phase = 0;
          model_start();
          m_drain = !enable;
        end
      end else begin
        m_phase++;
        m_drain = !enable;
      end
      if (acc) begin
        m_shadow = int'(duty_in);
        m_pend   = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("frec",  32'(Frec_Conm),    32'(m_on ? m_phase / (int'(prescale) + 1) : 0));
      check("ref",   32'(Corri_Ref),    32'(m_ref));
      check("ps",    32'(period_start), 32'(m_ps));
      check("run",   32'(running),      32'(m_on));
      check("rdy",   32'(duty_ready),   32'(!m_pend));
      check("clamp", 32'(duty_clamped), 32'(m_clamp));
    end
  end

  task automatic tick1();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 3000 && running; i++) tick1();
    check("wait_idle", 32'(running), 32'd0);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; period_top = '0; prescale = '0;
    duty_in = '0; duty_valid = 1'b0;
    tick1(); tick1();
    check("rst_frec", 32'(Frec_Conm), 0);
    check("rst_ref",  32'(Corri_Ref), 0);
    check("rst_rdy",  32'(duty_ready), 1);
    check("rst_run",  32'(running), 0);
    reset = 1'b0; period_top = 10'd9; prescale = 8'd0;
    duty_in = 10'd5; duty_valid = 1'b1;

    // Duty accepted in IDLE, then start
    tick1(); check("idle_acc_rdy", 32'(duty_ready), 0);
    duty_valid = 1'b0; enable = 1'b1;
    tick1();
    check("start_frec", 32'(Frec_Conm), 0);
    check("start_ref",  32'(Corri_Ref), 5);
    check("start_ps",   32'(period_start), 1);
    check("start_rdy",  32'(duty_ready), 1);
    repeat (9) tick1(); check("cnt9", 32'(Frec_Conm), 9);
    tick1(); check("wrap_frec", 32'(Frec_Conm), 0); check("wrap_ps", 32'(period_start), 1);

    // Mid-period duty update waits for the wrap
    repeat (3) tick1(); duty_in = 10'd7; duty_valid = 1'b1;
    tick1(); check("mid_rdy", 32'(duty_ready), 0); duty_valid = 1'b0;
    repeat (5) tick1(); check("old_ref", 32'(Corri_Ref), 5);
    tick1(); check("new_ref", 32'(Corri_Ref), 7); check("new_rdy", 32'(duty_ready), 1);

    // Clamp, then large and zero period_top
    duty_in = 10'd20; duty_valid = 1'b1;
    tick1(); duty_valid = 1'b0;
    repeat (8) tick1(); check("pre_clamp", 32'(Frec_Conm), 9);
    tick1(); check("clamp_ref", 32'(Corri_Ref), 10); check("clamp_pulse", 32'(duty_clamped), 1);
    period_top = 10'd1023;
    tick1(); check("clamp_end", 32'(duty_clamped), 0);
    repeat (9) tick1(); period_top = 10'd0;
    repeat (1022) tick1(); check("top_max", 32'(Frec_Conm), 1022);
    tick1(); check("top_max_wrap", 32'(Frec_Conm), 0);
    tick1(); check("top0_1", 32'(Frec_Conm), 1);
    tick1(); check("top0_wrap", 32'(Frec_Conm), 0);
    period_top = 10'd9;
    tick1(); tick1();

    // Stop drains to end of period; restart during drain is seamless
    repeat (4) tick1(); enable = 1'b0;
    tick1(); check("drain_run", 32'(running), 1);
    repeat (4) tick1(); check("drain_9", 32'(Frec_Conm), 9);
    tick1(); check("idle_run", 32'(running), 0); check("idle_ref", 32'(Corri_Ref), 0);
    enable = 1'b1;
    tick1(); check("restart_ps", 32'(period_start), 1);
    repeat (4) tick1(); enable = 1'b0;
    tick1(); tick1(); enable = 1'b1;
    tick1(); check("resume_7", 32'(Frec_Conm), 7);
    tick1(); tick1();
    tick1(); check("resume_wrap", 32'(Frec_Conm), 0); check("resume_run", 32'(running), 1);

    // Prescale 3
    enable = 1'b0; wait_idle();
    prescale = 8'd3; enable = 1'b1;
    tick1(); check("pre_start", 32'(period_start), 1);
    repeat (3) tick1(); check("pre_hold", 32'(Frec_Conm), 0);
    tick1(); check("pre_step", 32'(Frec_Conm), 1);
    repeat (35) tick1(); check("pre_9", 32'(Frec_Conm), 9);
    tick1(); check("pre_period", 32'(period_start), 1);

    // Reset with pending duty
    duty_in = 10'd9; duty_valid = 1'b1;
    tick1(); check("pend_rdy", 32'(duty_ready), 0);
    duty_valid = 1'b0; reset = 1'b1;
    tick1();
    check("mid_rst_rdy",  32'(duty_ready), 1);
    check("mid_rst_run",  32'(running), 0);
    check("mid_rst_frec", 32'(Frec_Conm), 0);
    reset = 1'b0; prescale = 8'd0;
    tick1(); check("no_stale_ref", 32'(Corri_Ref), 0); check("rst_restart", 32'(running), 1);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      tick1();
      reset = ($urandom_range(0, 999) == 0);
      if ($urandom_range(0, 19) == 0) enable = !enable;
      if (!m_on && $urandom_range(0, 3) == 0) prescale = 8'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) period_top = 10'($urandom_range(0, 14));
      if (!(duty_valid && m_pend)) begin
        duty_valid = ($urandom_range(0, 3) == 0);
        duty_in    = 10'($urandom_range(0, 20));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
